mem_wait_state_adapter: RTL
===========================

// Module: mem_wait_state_adapter
// PURPOSE
// - Sits between the picorv32 native memory port (mem_valid/mem_ready) and the look-ahead memory model.
// - Buffers one core request and inserts a fixed or pseudo-random number of wait states.
// - Issues exactly one single-cycle mem_la_read/mem_la_write pulse to the model per request.
// - Returns registered read data with a one-cycle mem_ready; counts transactions and flags core protocol violations.
// PARAMETERS
// - BUS_W      `SIZE_OF_THE_BUS  data/address width (32)
// - WAIT_W     4                 width of the wait-state count; max wait = 2**WAIT_W-1
// - LFSR_SEED  16'hACE1          LFSR reset value; a value of 0 is replaced by 16'hACE1
// PORTS
// - clk            in   1       clock; all state on posedge
// - resetn         in   1       asynchronous, active-low reset
// - mem_valid      in   1       core request valid; held until mem_ready
// - mem_instr      in   1       core: instruction fetch
// - mem_addr       in   BUS_W   core byte address
// - mem_wdata      in   BUS_W   core write data
// - mem_wstrb      in   4       core byte strobes; 0 = read
// - mem_ready      out  1       one-cycle completion pulse to core
// - mem_rdata      out  BUS_W   read data to core, valid while mem_ready=1
// - la_read        out  1       to model mem_la_read
// - la_write       out  1       to model mem_la_write
// - la_instr       out  1       to model mem_instr
// - la_addr        out  BUS_W   to model mem_la_addr
// - la_wdata       out  BUS_W   to model mem_la_wdata
// - la_wstrb       out  4       to model mem_la_wstrb
// - model_rdata    in   BUS_W   model mem_rdata; updated at the edge that samples la_read
// - cfg_rand_en    in   1       1 = random wait, 0 = fixed wait
// - cfg_wait       in   WAIT_W  fixed wait-state count
// - rd_count       out  32      completed reads; wraps at 2**32
// - wr_count       out  32      completed writes; wraps at 2**32
// - err_proto      out  1       sticky core protocol-violation flag
// BEHAVIOUR
// - Reset: all outputs 0, state IDLE, LFSR=seed. Assertion mid-transaction abandons the request; no la_* pulse after reset.
// - FSM: IDLE -> WAIT -> ISSUE -> CAPTURE -> DONE -> IDLE. Every output is registered.
// - IDLE: when mem_valid=1, latch addr/wdata/wstrb/instr into la_* and load the wait count N.
//   - N = cfg_wait if cfg_rand_en=0, else lfsr[WAIT_W-1:0].
//   - N=0: go to ISSUE. Otherwise go to WAIT.
// - WAIT: decrement the counter. On the cycle the count reaches 1, go to ISSUE.
// - ISSUE: exactly one cycle.
//   - la_read=1 if latched wstrb==0; otherwise la_write=1.
//   - la_addr, la_wdata and la_wstrb hold their latched values.
// - CAPTURE: la_read/la_write=0. At the end of the cycle, mem_rdata<=model_rdata for reads and 0 for writes; mem_ready<=1.
// - DONE: mem_ready=1 for exactly one cycle.
//   - Increment rd_count or wr_count at this edge.
//   - mem_ready and mem_rdata clear on exit.
//   - The next cycle is IDLE and may accept a new request immediately.
// - Latency: request accepted in cycle 0 gives mem_ready in cycle N+3 and the la_* pulse in cycle N+1.
// - LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances every cycle regardless of state.
// - Protocol errors set err_proto, cleared only by reset. The transaction still completes normally.
//   - mem_valid=0 in WAIT/ISSUE/CAPTURE.
//   - mem_addr/mem_wstrb differing from the latched value while mem_valid=1 in WAIT/ISSUE/CAPTURE.
// - la_addr is passed through unshifted as a byte address; the model does the word indexing.
// STRUCTURE
// - mem_adapter_pkg holds:
//   - typedef enum logic[2:0] {IDLE,WAIT,ISSUE,CAPTURE,DONE} adp_state_t
//   - LFSR_TAPS = 16'hB400 and DEFAULT_SEED = 16'hACE1
// - One sub-module, wait_lfsr (16-bit, seed parameter, enable tied high).
// TESTING
// - Read, cfg_wait=0, addr 0x100, model returns 0x00000013 -> la_read pulse cycle 1, mem_ready cycle 3, mem_rdata=0x13, rd_count=1.
// - Write, cfg_wait=5, addr 0x20000, wdata 0xDEADBEEF, wstrb 4'b0011 -> la_write cycle 6 with wstrb 0011, mem_ready cycle 8 with mem_rdata=0, wr_count=1.
// - Back-to-back: mem_valid held with new addr in the cycle after DONE -> second request accepted with no idle gap, exactly 2 la_* pulses.
// - cfg_rand_en=1, 1000 reads -> every wait in 0..15, sequence matches the wait_lfsr golden model from 16'hACE1, no cycle with both la_read and la_write.
// - Drop mem_valid during WAIT -> err_proto=1, transaction still completes, flag persists until resetn=0.
// - resetn asserted in CAPTURE -> mem_ready, la_* and counters are 0 immediately; after release, new read completes normally.

Source files
------------

// File: rtl/mem_wait_state_adapter_pkg.sv
// Shared types and constants for the wait-state memory adapter.
package mem_adapter_pkg;

    // Adapter sequencing: accept, stall, pulse the model, capture, complete.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT    = 3'd1,
        ISSUE   = 3'd2,
        CAPTURE = 3'd3,
        DONE    = 3'd4
    } adp_state_t;

    // Default data/address width of the core bus.
    localparam int BUS_W_DEFAULT = 32;

    // Fibonacci taps at register positions 16,14,13,11 (bits 15,13,12,10).
    localparam logic [15:0] LFSR_TAPS    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    // One LFSR step: shift left, feedback is the parity of the tapped bits.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/mem_wait_state_adapter_if.sv
// Bus bundle between the core-side memory port, the adapter and the
// look-ahead memory model.
//
// Handshake: the core raises mem_valid with a stable request (addr, wdata,
// wstrb, instr) and holds it until it sees mem_ready=1 for one cycle;
// mem_rdata is only meaningful while mem_ready=1. Toward the model there is
// no back-pressure: la_read/la_write are single-cycle strobes and the model
// presents model_rdata at the edge that samples la_read.
interface mem_wait_state_adapter_if #(
    parameter int BUS_W = 32
);
    // Core side
    logic             mem_valid;
    logic             mem_instr;
    logic [BUS_W-1:0] mem_addr;
    logic [BUS_W-1:0] mem_wdata;
    logic [3:0]       mem_wstrb;
    logic             mem_ready;
    logic [BUS_W-1:0] mem_rdata;

    // Model side
    logic             la_read;
    logic             la_write;
    logic             la_instr;
    logic [BUS_W-1:0] la_addr;
    logic [BUS_W-1:0] la_wdata;
    logic [3:0]       la_wstrb;
    logic [BUS_W-1:0] model_rdata;

    // The adapter itself
    modport slave (
        input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata,
        output la_read, la_write, la_instr, la_addr, la_wdata, la_wstrb,
        input  model_rdata
    );

    // Core plus memory model, seen from the adapter's environment
    modport master (
        output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata,
        input  la_read, la_write, la_instr, la_addr, la_wdata, la_wstrb,
        output model_rdata
    );
endinterface

// File: rtl/mem_wait_state_adapter_wait_lfsr.sv
// Free-running 16-bit Fibonacci LFSR used to pick pseudo-random wait counts.
module wait_lfsr
    import mem_adapter_pkg::*;
#(
    parameter logic [15:0] SEED = DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        en_i,
    output logic [15:0] lfsr_o
);

    // An all-zero seed would lock the register up, so substitute the default.
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? DEFAULT_SEED : SEED;

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    // Next value: advance when enabled.
    always_comb begin
        lfsr_d = en_i ? lfsr_next(lfsr_q) : lfsr_q;
    end

    // State register, restarts from the seed on reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lfsr_q <= SEED_EFF;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr_o = lfsr_q;

endmodule

// File: rtl/mem_wait_state_adapter.sv
// Buffers one core memory request, stalls it for a fixed or pseudo-random
// number of cycles, fires one look-ahead strobe at the model and returns a
// registered one-cycle completion. Also counts completions and latches any
// core protocol violation seen while a request is in flight.
module mem_wait_state_adapter
    import mem_adapter_pkg::*;
#(
    parameter int          BUS_W     = BUS_W_DEFAULT,
    parameter int          WAIT_W    = 4,
    parameter logic [15:0] LFSR_SEED = DEFAULT_SEED
) (
    input  logic                    clk,
    input  logic                    resetn,
    mem_wait_state_adapter_if.slave bus,
    input  logic                    cfg_rand_en,
    input  logic [WAIT_W-1:0]       cfg_wait,
    output logic [31:0]             rd_count,
    output logic [31:0]             wr_count,
    output logic                    err_proto,
    output adp_state_t              dbg_state
);

    adp_state_t        state_q, state_d;
    logic [WAIT_W-1:0] cnt_q, cnt_d;
    logic              la_read_q, la_read_d;
    logic              la_write_q, la_write_d;
    logic              la_instr_q, la_instr_d;
    logic [BUS_W-1:0]  la_addr_q, la_addr_d;
    logic [BUS_W-1:0]  la_wdata_q, la_wdata_d;
    logic [3:0]        la_wstrb_q, la_wstrb_d;
    logic              mem_ready_q, mem_ready_d;
    logic [BUS_W-1:0]  mem_rdata_q, mem_rdata_d;
    logic [31:0]       rd_count_q, rd_count_d;
    logic [31:0]       wr_count_q, wr_count_d;
    logic              err_q, err_d;

    logic [15:0]       lfsr;
    logic [WAIT_W-1:0] wait_n;
    logic              in_txn;
    logic              proto_viol;
    logic              unused_lfsr;

    wait_lfsr #(
        .SEED (LFSR_SEED)
    ) u_wait_lfsr (
        .clk    (clk),
        .resetn (resetn),
        .en_i   (1'b1),
        .lfsr_o (lfsr)
    );

    // Only the low bits of the LFSR set the wait count.
    assign unused_lfsr = ^lfsr[15:WAIT_W];
    assign wait_n      = cfg_rand_en ? lfsr[WAIT_W-1:0] : cfg_wait;

    // The core must keep the same request up from acceptance until completion.
    assign in_txn     = (state_q == WAIT) || (state_q == ISSUE) || (state_q == CAPTURE);
    assign proto_viol = in_txn && (!bus.mem_valid ||
                                   (bus.mem_addr  != la_addr_q) ||
                                   (bus.mem_wstrb != la_wstrb_q));

    // Next-state and datapath decode for the request sequencer.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        la_read_d   = 1'b0;
        la_write_d  = 1'b0;
        la_instr_d  = la_instr_q;
        la_addr_d   = la_addr_q;
        la_wdata_d  = la_wdata_q;
        la_wstrb_d  = la_wstrb_q;
        mem_ready_d = 1'b0;
        mem_rdata_d = '0;
        rd_count_d  = rd_count_q;
        wr_count_d  = wr_count_q;
        err_d       = err_q | proto_viol;

        case (state_q)
            IDLE: begin
                if (bus.mem_valid) begin
                    la_instr_d = bus.mem_instr;
                    la_addr_d  = bus.mem_addr;
                    la_wdata_d = bus.mem_wdata;
                    la_wstrb_d = bus.mem_wstrb;
                    cnt_d      = wait_n;
                    if (wait_n == '0) begin
                        // No stall: the strobe goes out in the very next cycle.
                        state_d    = ISSUE;
                        la_read_d  = (bus.mem_wstrb == 4'h0);
                        la_write_d = (bus.mem_wstrb != 4'h0);
                    end else begin
                        state_d = WAIT;
                    end
                end
            end

            WAIT: begin
                cnt_d = cnt_q - WAIT_W'(1);
                if (cnt_q == WAIT_W'(1)) begin
                    state_d    = ISSUE;
                    la_read_d  = (la_wstrb_q == 4'h0);
                    la_write_d = (la_wstrb_q != 4'h0);
                end
            end

            ISSUE: begin
                // Strobe drops on leaving; the model answers during CAPTURE.
                state_d = CAPTURE;
            end

            CAPTURE: begin
                state_d     = DONE;
                mem_ready_d = 1'b1;
                if (la_wstrb_q == 4'h0) begin
                    mem_rdata_d = bus.model_rdata;
                    rd_count_d  = rd_count_q + 32'd1;
                end else begin
                    wr_count_d  = wr_count_q + 32'd1;
                end
            end

            DONE: begin
                // mem_ready/mem_rdata fall back to their defaults here.
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // All sequencer state and every output is registered here.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            la_read_q   <= 1'b0;
            la_write_q  <= 1'b0;
            la_instr_q  <= 1'b0;
            la_addr_q   <= '0;
            la_wdata_q  <= '0;
            la_wstrb_q  <= 4'h0;
            mem_ready_q <= 1'b0;
            mem_rdata_q <= '0;
            rd_count_q  <= 32'd0;
            wr_count_q  <= 32'd0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            la_read_q   <= la_read_d;
            la_write_q  <= la_write_d;
            la_instr_q  <= la_instr_d;
            la_addr_q   <= la_addr_d;
            la_wdata_q  <= la_wdata_d;
            la_wstrb_q  <= la_wstrb_d;
            mem_ready_q <= mem_ready_d;
            mem_rdata_q <= mem_rdata_d;
            rd_count_q  <= rd_count_d;
            wr_count_q  <= wr_count_d;
            err_q       <= err_d;
        end
    end

    assign bus.mem_ready = mem_ready_q;
    assign bus.mem_rdata = mem_rdata_q;
    assign bus.la_read   = la_read_q;
    assign bus.la_write  = la_write_q;
    assign bus.la_instr  = la_instr_q;
    assign bus.la_addr   = la_addr_q;
    assign bus.la_wdata  = la_wdata_q;
    assign bus.la_wstrb  = la_wstrb_q;
    assign rd_count      = rd_count_q;
    assign wr_count      = wr_count_q;
    assign err_proto     = err_q;
    assign dbg_state     = state_q;

endmodule
